// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, assembles big-endian 16-bit instructions from a byte-wide
// request/acknowledge memory and queues them with their PC for the datapath.
module instruction_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'd10,
    parameter int          DEPTH    = 2
) (
    input  logic                     Clock,
    input  logic                     ResetN,
    output logic                     MemReq,
    output logic [15:0]              MemAddr,
    input  logic                     MemAck,
    input  logic [7:0]               MemRdata,
    output logic                     InstrValid,
    input  logic                     InstrReady,
    output logic [15:0]              Instruction,
    output logic [15:0]              InstrPC,
    input  logic                     Redirect,
    input  logic [15:0]              RedirectPC,
    output logic [$clog2(DEPTH):0]   QCount
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH_HI, FETCH_LO, DRAIN} state_t;

    state_t          state, state_next;
    logic [15:0]     pc, pc_next, mem_addr;
    logic [7:0]      hi_byte;
    logic [CW-1:0]   count, count_next;
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [15:0]     head_instr, head_pc;
    logic [15:0]     q_instr [DEPTH];
    logic [15:0]     q_pc    [DEPTH];
    logic            accept, push, pop, load_addr;
    logic [15:0]     push_instr;

    assign push_instr = {hi_byte, MemRdata};

    // Handshake events; a redirect suppresses both queue operations in its cycle.
    // NOTE: every signal assigned in a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        accept     = (state != IDLE) && MemAck;
        push       = (state == FETCH_LO) && accept && !Redirect;
        pop        = (count != '0) && InstrReady && !Redirect;
        count_next = count;
        if (Redirect) begin
            count_next = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_next = count + CW'(1);
                2'b01:   count_next = count - CW'(1);
                default: count_next = count;
            endcase
        end
        pc_next = pc;
        if (Redirect)  pc_next = {RedirectPC[15:1], 1'b0};
        else if (push) pc_next = pc + 16'd2;
    end

    // State register
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (Redirect || count < FULL) state_next = FETCH_HI;
            FETCH_HI: begin
                if (Redirect)    state_next = accept ? FETCH_HI : DRAIN;
                else if (accept) state_next = FETCH_LO;
            end
            FETCH_LO: begin
                if (Redirect)    state_next = accept ? FETCH_HI : DRAIN;
                else if (accept) state_next = (count_next < FULL) ? FETCH_HI : IDLE;
            end
            DRAIN:    if (accept) state_next = FETCH_HI;
            default:  state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        MemReq      = (state != IDLE);
        MemAddr     = mem_addr;
        InstrValid  = (count != '0);
        Instruction = head_instr;
        InstrPC     = head_pc;
        QCount      = count;
    end

    // The address only moves when no request is outstanding; DRAIN keeps the stale request stable.
    assign load_addr = ((state == IDLE) || accept) && (state_next != DRAIN);

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            pc         <= RESET_PC;
            mem_addr   <= RESET_PC;
            hi_byte    <= '0;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            head_instr <= '0;
            head_pc    <= '0;
        end else begin
            pc    <= pc_next;
            count <= count_next;
            if (load_addr)
                mem_addr <= (state_next == FETCH_LO) ? {pc[15:1], 1'b1} : pc_next;
            if (state == FETCH_HI && accept && !Redirect)
                hi_byte <= MemRdata;
            if (Redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                // Head register tracks the entry that will be at the front next cycle.
                if (pop) begin
                    if (push && count == CW'(1)) begin
                        head_instr <= push_instr;
                        head_pc    <= pc;
                    end else if (count > CW'(1)) begin
                        head_instr <= q_instr[rd_ptr + PW'(1)];
                        head_pc    <= q_pc[rd_ptr + PW'(1)];
                    end
                end else if (push && count == '0) begin
                    head_instr <= push_instr;
                    head_pc    <= pc;
                end
            end
        end
    end

    // NOTE: queue storage has no reset; occupancy and the head register define what is visible.
    always_ff @(posedge Clock) begin
        if (push) begin
            q_instr[wr_ptr] <= push_instr;
            q_pc[wr_ptr]    <= pc;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed phases push expected instructions,
// a negedge monitor pops and compares every accepted instruction.
module tb_instruction_fetch_unit;

    logic        Clock = 1'b0;
    logic        ResetN;
    logic        MemReq;
    logic [15:0] MemAddr;
    logic        MemAck;
    logic [7:0]  MemRdata;
    logic        InstrValid;
    logic        InstrReady;
    logic [15:0] Instruction;
    logic [15:0] InstrPC;
    logic        Redirect;
    logic [15:0] RedirectPC;
    logic [1:0]  QCount;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
    } item_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          n_popped = 0;
    int          wait_n   = 0;
    int          wcnt     = 0;
    logic        prev_req = 1'b0;
    logic [15:0] prev_addr = '0;
    logic [7:0]  mem [0:65535];
    item_t       sb [$];
    int          pop_cyc [$];

    instruction_fetch_unit #(.RESET_PC(16'd10), .DEPTH(2)) dut (
        .Clock       (Clock),
        .ResetN      (ResetN),
        .MemReq      (MemReq),
        .MemAddr     (MemAddr),
        .MemAck      (MemAck),
        .MemRdata    (MemRdata),
        .InstrValid  (InstrValid),
        .InstrReady  (InstrReady),
        .Instruction (Instruction),
        .InstrPC     (InstrPC),
        .Redirect    (Redirect),
        .RedirectPC  (RedirectPC),
        .QCount      (QCount)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic expect_instr(input logic [15:0] instr, input logic [15:0] pc);
        item_t e;
        e.instr = instr;
        e.pc    = pc;
        sb.push_back(e);
    endtask

    task automatic wait_pops(input int target, input int budget);
        int k = 0;
        while (n_popped < target && k < budget) begin
            tick();
            k++;
        end
        check("pops_reached", n_popped, target);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((MemReq || QCount != 2'd2) && k < budget) begin
            tick();
            k++;
        end
        check("idle_full_reached", {MemReq, QCount}, {1'b0, 2'd2});
    endtask

    // Memory model with programmable wait states; also checks the address stays put while waiting.
    always @(negedge Clock) begin
        if (ResetN && prev_req && !MemAck && MemReq)
            check("addr_hold", MemAddr, prev_addr);
        prev_req  = ResetN && MemReq;
        prev_addr = MemAddr;
        if (ResetN && MemReq) begin
            if (wcnt >= wait_n) begin
                MemAck   = 1'b1;
                MemRdata = mem[MemAddr];
                wcnt     = 0;
            end else begin
                MemAck   = 1'b0;
                MemRdata = 8'h00;
                wcnt++;
            end
        end else begin
            MemAck = 1'b0;
            wcnt   = 0;
        end
    end

    // Scoreboard monitor
    always @(negedge Clock) begin
        item_t e;
        if (ResetN && InstrValid && InstrReady && !Redirect) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_instr: got 0x%04h at pc 0x%04h, expected nothing (cycle %0d)",
                         Instruction, InstrPC, cyc);
            end else begin
                e = sb.pop_front();
                check("instr_pc", {Instruction, InstrPC}, {e.instr, e.pc});
            end
            n_popped++;
            pop_cyc.push_back(cyc);
        end
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = i[7:0];
        mem[16'h000A] = 8'h12; mem[16'h000B] = 8'h34;
        mem[16'h000C] = 8'h56; mem[16'h000D] = 8'h78;
        mem[16'h000E] = 8'h9A; mem[16'h000F] = 8'hBC;
        mem[16'h0020] = 8'hC3; mem[16'h0021] = 8'h3C;
        mem[16'hFFFE] = 8'hDE; mem[16'hFFFF] = 8'hAD;
        mem[16'h0000] = 8'hBE; mem[16'h0001] = 8'hEF;
        MemAck = 1'b0; MemRdata = 8'h00;
        ResetN = 1'b0; InstrReady = 1'b0; Redirect = 1'b0; RedirectPC = 16'h0000;

        // Reset values
        repeat (3) tick();
        check("rst_memreq", MemReq, 1'b0);
        check("rst_memaddr", MemAddr, 16'h000A);
        check("rst_valid", InstrValid, 1'b0);
        check("rst_instr", Instruction, 16'h0000);
        check("rst_instrpc", InstrPC, 16'h0000);
        check("rst_qcount", QCount, 2'd0);

        // First fetch timing from reset release, with the datapath stalled
        ResetN = 1'b1;
        @(negedge Clock); check("c0_memreq", MemReq, 1'b0);
        @(negedge Clock); check("c1_memreq", MemReq, 1'b1); check("c1_addr", MemAddr, 16'h000A);
        @(negedge Clock); check("c2_addr", MemAddr, 16'h000B); check("c2_valid", InstrValid, 1'b0);
        @(negedge Clock); check("c3_valid", InstrValid, 1'b1);
        check("c3_instr", Instruction, 16'h1234); check("c3_pc", InstrPC, 16'h000A);

        // Backpressure: queue fills, fetch parks in IDLE
        wait_idle(30);
        repeat (3) tick();
        check("bp_memreq", MemReq, 1'b0);
        check("bp_qcount", QCount, 2'd2);

        // Release: in-order delivery, steady state one per two cycles
        expect_instr(16'h1234, 16'h000A);
        expect_instr(16'h5678, 16'h000C);
        expect_instr(16'h9ABC, 16'h000E);
        expect_instr(16'h1011, 16'h0010);
        InstrReady = 1'b1;
        wait_pops(4, 40);
        InstrReady = 1'b0;
        check("pop_gap", (pop_cyc.size() >= 4) ? pop_cyc[3] - pop_cyc[2] : -1, 2);

        // Redirect from IDLE with a full queue; odd target PC
        wait_idle(30);
        RedirectPC = 16'h0021; Redirect = 1'b1;
        tick();
        Redirect = 1'b0;
        @(negedge Clock);
        check("ri_memreq", MemReq, 1'b1); check("ri_addr", MemAddr, 16'h0020);
        check("ri_qcount", QCount, 2'd0); check("ri_valid", InstrValid, 1'b0);
        @(negedge Clock); check("ri_addr_lo", MemAddr, 16'h0021); check("ri_valid2", InstrValid, 1'b0);
        @(negedge Clock); check("ri_valid3", InstrValid, 1'b1);
        check("ri_instr", Instruction, 16'hC33C); check("ri_pc", InstrPC, 16'h0020);
        tick();
        expect_instr(16'hC33C, 16'h0020);
        InstrReady = 1'b1;
        wait_pops(5, 20);
        InstrReady = 1'b0;

        // Redirect while a slow request is pending, then a second redirect during the drain
        wait_idle(30);
        wait_n = 3;
        expect_instr(16'h2223, 16'h0022);
        InstrReady = 1'b1;
        wait_pops(6, 10);
        InstrReady = 1'b0;
        tick();
        check("pd_memreq", MemReq, 1'b1); check("pd_addr", MemAddr, 16'h0026);
        Redirect = 1'b1; RedirectPC = 16'h0050;
        tick();
        RedirectPC = 16'h0061;
        check("pd_drain_addr", MemAddr, 16'h0026); check("pd_flush", QCount, 2'd0);
        tick();
        Redirect = 1'b0;
        @(negedge Clock);
        check("pd_hold_req", MemReq, 1'b1); check("pd_hold_addr", MemAddr, 16'h0026);
        check("pd_valid", InstrValid, 1'b0);
        @(negedge Clock);
        @(negedge Clock);
        check("pd_new_req", MemReq, 1'b1); check("pd_new_addr", MemAddr, 16'h0060);
        tick();
        expect_instr(16'h6061, 16'h0060);
        InstrReady = 1'b1;
        wait_pops(7, 60);
        InstrReady = 1'b0;
        wait_n = 0;

        // PC wrap at the top of the address space
        wait_idle(60);
        RedirectPC = 16'hFFFE; Redirect = 1'b1;
        tick();
        Redirect = 1'b0;
        @(negedge Clock); check("wr_addr_hi", MemAddr, 16'hFFFE); check("wr_req", MemReq, 1'b1);
        @(negedge Clock); check("wr_addr_lo", MemAddr, 16'hFFFF);
        @(negedge Clock); check("wr_addr_next", MemAddr, 16'h0000);
        check("wr_instr", Instruction, 16'hDEAD); check("wr_pc", InstrPC, 16'hFFFE);
        tick();
        expect_instr(16'hDEAD, 16'hFFFE);
        expect_instr(16'hBEEF, 16'h0000);
        InstrReady = 1'b1;
        wait_pops(9, 20);
        InstrReady = 1'b0;

        // Asynchronous reset in the middle of a low-byte fetch
        wait_idle(30);
        RedirectPC = 16'h0080; Redirect = 1'b1;
        tick();
        Redirect = 1'b0;
        tick();
        check("mr_lo_addr", MemAddr, 16'h0081);
        ResetN = 1'b0;
        #1;
        check("mr_memreq", MemReq, 1'b0); check("mr_qcount", QCount, 2'd0);
        check("mr_valid", InstrValid, 1'b0); check("mr_addr", MemAddr, 16'h000A);
        check("mr_instr", Instruction, 16'h0000);
        tick();
        ResetN = 1'b1;
        @(negedge Clock); check("mr_c0_req", MemReq, 1'b0);
        @(negedge Clock); check("mr_c1_req", MemReq, 1'b1); check("mr_c1_addr", MemAddr, 16'h000A);
        tick();
        expect_instr(16'h1234, 16'h000A);
        InstrReady = 1'b1;
        wait_pops(10, 20);
        InstrReady = 1'b0;

        repeat (4) tick();
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
